// File: rtl/mux_1_2_32bit_pkg.sv
// Shared constants for the 2:1 write-back select mux.
// Holds the default data width and the select encodings.
package mux_1_2_32bit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_1_2_32bit_if.sv
// Select/data bundle for mux_1_2_32bit; the master drives select, data and enable.
// The slave returns the combinational result and the registered result.
interface mux_1_2_32bit_if
  import mux_1_2_32bit_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic             sel;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;

  modport master (
    output sel, in0, in1, en,
    input  out, out_q, sel_q
  );

  modport slave (
    input  sel, in0, in1, en,
    output out, out_q, sel_q
  );

endinterface

// File: rtl/mux_1_2_32bit_mux_out_reg.sv
// Enable/reset capture register, W bits wide, one cycle latency, holds while en=0.
// Starts at RESET_VAL before any clock so the output is defined from time zero.
module mux_out_reg #(
  parameter int           W         = 33,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clkd,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q = RESET_VAL;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Reset overrides the enable.
  always_ff @(posedge clkd) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/mux_1_2_32bit.sv
// 2:1 data mux: out is combinational (zero latency, unaffected by rst);
// out_q/sel_q capture out/sel one clkd cycle later when en=1, and hold when en=0.
module mux_1_2_32bit
  import mux_1_2_32bit_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clkd,
  input  logic                  rst,
  mux_1_2_32bit_if.slave        bus
);

  logic [WIDTH-1:0] mux_dat;
  logic [WIDTH:0]   reg_d;
  logic [WIDTH:0]   reg_q;

  always_comb begin
    mux_dat = bus.in0;
    if (bus.sel == SEL_IN1) begin
      mux_dat = bus.in1;
    end
  end

  assign bus.out = mux_dat;

  // Select bit rides in the MSB so it stays aligned with the captured data.
  assign reg_d = {bus.sel, mux_dat};

  mux_out_reg #(
    .W         (WIDTH + 1),
    .RESET_VAL ({SEL_IN0, RESET_VAL})
  ) u_out_reg (
    .clkd (clkd),
    .rst  (rst),
    .en   (bus.en),
    .d    (reg_d),
    .q    (reg_q)
  );

  assign bus.sel_q = reg_q[WIDTH];
  assign bus.out_q = reg_q[WIDTH-1:0];

endmodule

// File: tb/tb_mux_1_2_32bit.sv
// Directed bench for mux_1_2_32bit: combinational path, capture/hold, reset and release.
module tb_mux_1_2_32bit;

  logic clkd;
  logic rst;
  int   checks;
  int   errors;

  mux_1_2_32bit_if #(.WIDTH(32)) bus ();
  mux_1_2_32bit_if #(.WIDTH(32)) bus2 ();

  mux_1_2_32bit #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clkd (clkd),
    .rst  (rst),
    .bus  (bus)
  );

  // Second instance with a non-zero reset value, sharing the same stimulus.
  mux_1_2_32bit #(.WIDTH(32), .RESET_VAL(32'hCAFE_F00D)) dut2 (
    .clkd (clkd),
    .rst  (rst),
    .bus  (bus2)
  );

  assign bus2.sel = bus.sel;
  assign bus2.in0 = bus.in0;
  assign bus2.in1 = bus.in1;
  assign bus2.en  = bus.en;

  initial clkd = 1'b0;
  always #5 clkd = ~clkd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkd);
    #1;
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] exp_q;
    logic        exp_sel;
    checks = 0;
    errors = 0;

    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.sel = 1'b0;
    bus.in0 = 32'h1234_5678;
    bus.in1 = 32'hDEAD_BEEF;
    #1;
    check("t0_out_q", bus.out_q, 32'h0);
    check("t0_sel_q", {31'b0, bus.sel_q}, 32'h0);
    check("t0_out_q_rv", bus2.out_q, 32'hCAFE_F00D);
    check("t0_sel_q_rv", {31'b0, bus2.sel_q}, 32'h0);
    check("out_in_reset", bus.out, 32'h1234_5678);

    step();
    check("rst_out_q_rv", bus2.out_q, 32'hCAFE_F00D);
    rst    = 1'b0;
    bus.en = 1'b1;

    step();
    check("sel0_out_q", bus.out_q, 32'h1234_5678);
    check("sel0_sel_q", {31'b0, bus.sel_q}, 32'h0);

    bus.sel = 1'b1;
    #1;
    check("sel1_out", bus.out, 32'hDEAD_BEEF);
    check("sel1_out_q_before_edge", bus.out_q, 32'h1234_5678);
    step();
    check("sel1_out_q", bus.out_q, 32'hDEAD_BEEF);
    check("sel1_sel_q", {31'b0, bus.sel_q}, 32'h1);

    // Walking ones on the selected input, complement on the other one.
    bus.sel = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pat     = 32'h1 << i;
      bus.in1 = pat;
      bus.in0 = ~pat;
      #1;
      check($sformatf("walk_in1_%0d", i), bus.out, pat);
    end
    bus.in1 = 32'hFFFF_FFFF; bus.in0 = 32'h0; #1;
    check("in1_all_ones", bus.out, 32'hFFFF_FFFF);
    bus.in1 = 32'h0; bus.in0 = 32'hFFFF_FFFF; #1;
    check("in1_all_zero", bus.out, 32'h0);
    bus.sel = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pat     = 32'h1 << i;
      bus.in0 = pat;
      bus.in1 = ~pat;
      #1;
      check($sformatf("walk_in0_%0d", i), bus.out, pat);
    end
    bus.in0 = 32'hFFFF_FFFF; bus.in1 = 32'h0; #1;
    check("in0_all_ones", bus.out, 32'hFFFF_FFFF);
    bus.in0 = 32'h0; bus.in1 = 32'hFFFF_FFFF; #1;
    check("in0_all_zero", bus.out, 32'h0);

    bus.in0 = 32'h5A5A_0F0F; bus.in1 = 32'h5A5A_0F0F;
    bus.sel = 1'b0; #1;
    check("equal_sel0", bus.out, 32'h5A5A_0F0F);
    bus.sel = 1'b1; #1;
    check("equal_sel1", bus.out, 32'h5A5A_0F0F);

    // Capture a known value, then hold with en=0 while inputs move.
    bus.in1 = 32'hA5A5_A5A5;
    step();
    check("hold_capture", bus.out_q, 32'hA5A5_A5A5);
    bus.en  = 1'b0;
    bus.sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in0 = 32'h0BAD_0000 + i;
      bus.in1 = 32'h0F00_0000 + i;
      #1;
      check($sformatf("hold_out_%0d", i), bus.out, 32'h0BAD_0000 + i);
      step();
      check($sformatf("hold_out_q_%0d", i), bus.out_q, 32'hA5A5_A5A5);
      check($sformatf("hold_sel_q_%0d", i), {31'b0, bus.sel_q}, 32'h1);
    end

    // Reset beats enable; combinational output unaffected.
    bus.en  = 1'b1;
    bus.sel = 1'b1;
    bus.in0 = 32'h1234_5678;
    bus.in1 = 32'hDEAD_BEEF;
    rst     = 1'b1;
    step();
    check("rst_out_q", bus.out_q, 32'h0);
    check("rst_sel_q", {31'b0, bus.sel_q}, 32'h0);
    check("rst_out", bus.out, 32'hDEAD_BEEF);
    check("rst_out_q_rv2", bus2.out_q, 32'hCAFE_F00D);

    rst = 1'b0;
    step();
    check("release_out_q", bus.out_q, 32'hDEAD_BEEF);
    check("release_sel_q", {31'b0, bus.sel_q}, 32'h1);

    // Toggle select every cycle; out_q follows the previous cycle's choice.
    for (int i = 0; i < 6; i++) begin
      bus.sel = i[0];
      bus.in0 = 32'h1000_0000 + i;
      bus.in1 = 32'h2000_0000 + i;
      exp_sel = i[0];
      exp_q   = exp_sel ? (32'h2000_0000 + i) : (32'h1000_0000 + i);
      step();
      check($sformatf("toggle_out_q_%0d", i), bus.out_q, exp_q);
      check($sformatf("toggle_sel_q_%0d", i), {31'b0, bus.sel_q}, {31'b0, exp_sel});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
